// File: rtl/ntt_pkg.sv
// Shared NTT definitions: FSM state encodings, default modulus/root,
// modular reduction and a constant-width helper.
package ntt_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_COMPUTE = 2'd1,
    S_EMIT    = 2'd2
  } ntt_state_e;

  localparam int DEFAULT_Q = 17;
  localparam int DEFAULT_W = 4;

  // Reduce x by the modulus q; result fits in 16 bits because q < 2**16.
  function automatic logic [15:0] mod_q(input logic [31:0] x, input logic [31:0] q);
    return 16'(x % q);
  endfunction

  // Ceiling log2 for elaboration-time sizing of index counters.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ntt_mod_butterfly.sv
// Combinational Cooley-Tukey butterfly modulo Q:
//   x = (a + tw*b) mod Q, y = (a - tw*b) mod Q, with a, b, tw already < Q.
module ntt_mod_butterfly
  import ntt_pkg::*;
#(
  parameter int Q = DEFAULT_Q
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] tw,
  output logic [15:0] x,
  output logic [15:0] y
);

  localparam logic [31:0] Q32 = 32'(Q);
  localparam logic [16:0] Q17 = 17'(Q);

  logic [31:0] prod;
  logic [15:0] t;
  logic [16:0] sum;
  logic [16:0] diff;

  // Product reduced once, then sum/difference need only one conditional subtract.
  always_comb begin
    prod = 32'(tw) * 32'(b);
    t    = mod_q(prod, Q32);
    sum  = 17'(a) + 17'(t);
    diff = 17'(a) + Q17 - 17'(t);
    x    = (sum  >= Q17) ? 16'(sum  - Q17) : sum[15:0];
    y    = (diff >= Q17) ? 16'(diff - Q17) : diff[15:0];
  end

endmodule

// File: rtl/ntt_butterfly_stage.sv
// One Cooley-Tukey butterfly stage over an N-word frame modulo Q.
// Collects a frame, runs N/2 butterflies (one per cycle), then emits
// the N results under valid/ready. One frame in flight at a time.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_COLLECT | accepting input words into mem[cnt]
//   S_COMPUTE | butterfly k=cnt on mem[k], mem[k+N/2]
//   S_EMIT    | presenting mem[cnt] on out_data until accepted
module ntt_butterfly_stage
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int Q          = DEFAULT_Q,
  parameter int W          = DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int              CW       = clog2(N);
  localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]   LAST_K   = CW'(N / 2 - 1);
  localparam logic [CW-1:0]   HALF     = CW'(N / 2);
  localparam logic [31:0]     Q32      = 32'(Q);
  localparam logic [31:0]     W32      = 32'(W % Q);

  ntt_state_e    state;
  ntt_state_e    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_idx;
  logic [15:0]   tw_q;
  logic [15:0]   tw_nx;
  logic [15:0]   mem [N];
  logic [15:0]   out_word;
  logic          out_valid_q;
  logic [15:0]   in_res;
  logic [15:0]   bf_x;
  logic [15:0]   bf_y;
  logic          in_fire;
  logic          out_fire;

  assign in_ready  = (state == S_COLLECT);
  assign busy      = (state == S_COMPUTE) || (state == S_EMIT);
  assign out_valid = out_valid_q;
  assign out_data  = DATA_WIDTH'(out_word);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign hi_idx    = cnt + HALF;
  assign in_res    = mod_q(32'(in_data), Q32);
  assign tw_nx     = mod_q(32'(tw_q) * W32, Q32);

  ntt_mod_butterfly #(.Q(Q)) u_bfly (
    .a  (mem[cnt]),
    .b  (mem[hi_idx]),
    .tw (tw_q),
    .x  (bf_x),
    .y  (bf_y)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_nx;
  end

  // Next-state decode; unknown encodings fall back to collecting.
  always_comb begin
    state_nx = state;
    case (state)
      S_COLLECT: if (in_fire && cnt == LAST_IDX)  state_nx = S_COMPUTE;
      S_COMPUTE: if (cnt == LAST_K)               state_nx = S_EMIT;
      S_EMIT:    if (out_fire && cnt == LAST_IDX) state_nx = S_COLLECT;
      default:                                    state_nx = S_COLLECT;
    endcase
  end

  // Index counter, twiddle register and registered output word.
  // The output register loads on the first S_EMIT cycle, giving N/2+1 cycles of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      tw_q        <= 16'd1;
      out_word    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_fire) begin
            if (cnt == LAST_IDX) begin
              cnt  <= '0;
              tw_q <= 16'd1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_COMPUTE: begin
          tw_q <= tw_nx;
          if (cnt == LAST_K) cnt <= '0;
          else               cnt <= cnt + CW'(1);
        end
        S_EMIT: begin
          if (!out_valid_q) begin
            out_word    <= mem[cnt];
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            if (cnt == LAST_IDX) begin
              cnt         <= '0;
              out_word    <= '0;
              out_valid_q <= 1'b0;
            end else begin
              cnt      <= cnt + CW'(1);
              out_word <= mem[cnt + CW'(1)];
            end
          end
        end
        default: begin
          cnt         <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer: reduced inputs on collect, butterfly results in place on compute.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[cnt] <= in_res;
    end else if (state == S_COMPUTE) begin
      mem[cnt]    <= bf_x;
      mem[hi_idx] <= bf_y;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// Directed bench for ntt_butterfly_stage (N=4, Q=17, W=4) with hand-computed results.
module tb_ntt_butterfly_stage;

  typedef logic [31:0] frame_t [4];

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks;
  int errors;

  ntt_butterfly_stage #(.DATA_WIDTH(32), .N(4), .Q(17), .W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge. in_valid stays high.
  task automatic send_word(input logic [31:0] d, input string tag);
    int guard;
    guard    = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input frame_t f, input string tag, input bit drop_valid);
    for (int i = 0; i < 4; i++) send_word(f[i], tag);
    if (drop_valid) in_valid = 1'b0;
  endtask

  // Receives four words with out_ready high; optionally checks first-valid latency.
  task automatic recv_frame(input frame_t e, input string tag, input int exp_lat);
    int lat;
    lat       = 0;
    out_ready = 1'b1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_word%0d", tag, i), out_data, e[i]);
      @(negedge clk);
    end
    check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    frame_t fa;
    frame_t fe;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame with latency
    fa = '{32'd1, 32'd2, 32'd3, 32'd4};
    fe = '{32'd4, 32'd1, 32'd15, 32'd3};
    send_frame(fa, "f1", 1'b1);
    check("f1_busy", {31'd0, busy}, 32'd1);
    check("f1_in_ready_busy", {31'd0, in_ready}, 32'd0);
    recv_frame(fe, "f1", 3);
    check("f1_busy_after", {31'd0, busy}, 32'd0);

    // 2: all Q-1 and all zero
    fa = '{32'd16, 32'd16, 32'd16, 32'd16};
    fe = '{32'd15, 32'd12, 32'd0, 32'd3};
    send_frame(fa, "f16", 1'b1);
    recv_frame(fe, "f16", 3);
    fa = '{32'd0, 32'd0, 32'd0, 32'd0};
    fe = '{32'd0, 32'd0, 32'd0, 32'd0};
    send_frame(fa, "f0", 1'b1);
    recv_frame(fe, "f0", 3);

    // 3: unreduced inputs
    fa = '{32'd18, 32'd19, 32'd20, 32'd21};
    fe = '{32'd4, 32'd1, 32'd15, 32'd3};
    send_frame(fa, "funred", 1'b1);
    recv_frame(fe, "funred", 3);

    // 4: backpressure mid-emit on frame 5,6,7,8 -> 12,4,15,8
    fa = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_frame(fa, "bp", 1'b1);
    out_ready = 1'b1;
    for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
    check("bp_word0", out_data, 32'd12);
    @(negedge clk);
    check("bp_word1", out_data, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold_data%0d", i), out_data, 32'd4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_word2", out_data, 32'd15);
    @(negedge clk);
    check("bp_word3", out_data, 32'd8);
    @(negedge clk);
    check("bp_valid_after", {31'd0, out_valid}, 32'd0);

    // 5: in_valid held high across two back-to-back frames
    fa = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_frame(fa, "b2b_a", 1'b0);
    in_data = 32'd16;
    check("b2b_in_ready_compute", {31'd0, in_ready}, 32'd0);
    fe = '{32'd12, 32'd4, 32'd15, 32'd8};
    recv_frame(fe, "b2b_a", 3);
    check("b2b_in_ready_back", {31'd0, in_ready}, 32'd1);
    fa = '{32'd16, 32'd16, 32'd16, 32'd16};
    send_frame(fa, "b2b_b", 1'b1);
    fe = '{32'd15, 32'd12, 32'd0, 32'd3};
    recv_frame(fe, "b2b_b", 3);

    // 6a: reset after two inputs drops the partial frame
    send_word(32'd9, "rst2");
    send_word(32'd10, "rst2");
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fa = '{32'd1, 32'd2, 32'd3, 32'd4};
    fe = '{32'd4, 32'd1, 32'd15, 32'd3};
    send_frame(fa, "rst2_f", 1'b1);
    recv_frame(fe, "rst2_f", 3);

    // 6b: reset during emit clears outputs immediately; nothing follows
    fa = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_frame(fa, "rste", 1'b1);
    for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
    check("rste_word0", out_data, 32'd12);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rste_out_valid", {31'd0, out_valid}, 32'd0);
    check("rste_out_data", out_data, 32'd0);
    check("rste_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rste_quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end
    fa = '{32'd18, 32'd19, 32'd20, 32'd21};
    fe = '{32'd4, 32'd1, 32'd15, 32'd3};
    send_frame(fa, "rste_f", 1'b1);
    recv_frame(fe, "rste_f", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
